shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Multi-cycle sequencer that performs variable-count 16-bit rotates and shifts by repeatedly applying a single 1-bit shift stage to an internal working register. It sits between the ALU issue logic and the shifter datapath. It replaces a 4-level barrel network with one stage plus a counter, trading latency for area. Requests use a valid/ready handshake and results a second valid/ready handshake; one operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 16, datapath width. Only 16 is supported.
- CNT_W, 4, shift-count width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_data  in  16  operand.
- in_cnt  in  4  shift/rotate amount, 0–15.
- in_op  in  2  operation: 00 rol, 01 sll, 10 ror, 11 srl.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  result; stable while out_valid is high.
- busy  out  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is 2 bits: IDLE=00, SHIFT=01, DONE=10. The value 11 is illegal and recovers to IDLE.
- IDLE: in_ready=1. When in_valid is high, the block captures in_data into the work register, in_op into the op register, and in_cnt into rem. Next state is SHIFT if in_cnt≠0, otherwise DONE.
- SHIFT: each edge performs one step on the work register and decrements rem. When rem reaches 0 after the decrement, next state is DONE. in_valid is ignored in this state.
- Step definitions, with d = work register:
  - rol: {d[14:0],d[15]}
  - sll: {d[14:0],1'b0}
  - ror: {d[0],d[15:1]}
  - srl: {1'b0,d[15:1]}
- DONE: out_valid=1 and out_data=work register. When out_ready is high, next state is IDLE. There is no same-cycle bypass into a new accept.
- The op is latched at accept; changes on in_op afterwards have no effect.
- A rotate by 0 and a shift by 0 both return the operand unchanged.
- Reset values, applied asynchronously by rst_n low in any state:
  - state=IDLE
  - work=0, rem=0, op=00
  - in_ready=1, out_valid=0, busy=0, out_data=0
- Reset mid-operation drops the operation and produces no output.

## Timing
- Accept on edge E0, when in_valid and in_ready are both high.
- With N = in_cnt: the step edges are E1..EN, and out_valid is high in the cycle after edge EN. For N=0, out_valid is high in the cycle right after E0.
- The result handshake completes on edge F, when out_valid and out_ready are both high. in_ready is high in the cycle after F.
- Minimum request-to-request spacing is N+2 cycles.
- out_data holds indefinitely under backpressure (out_ready low).
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- SHIFT_BY4_EN defined:
  - SHIFT steps by 4 bits while rem≥4 and decrements rem by 4; otherwise it steps by 1.
  - Step edges = in_cnt[3:2] + in_cnt[1:0]. For example, cnt=15 takes 6 edges and cnt=8 takes 2.
  - The results are identical to the undefined case.
- SHIFT_BY4_EN undefined:
  - Only the 1-bit step exists.
  - Step edges = in_cnt.

## Structure
- Shared package shift_ctrl_pkg holds:
  - op codes OP_ROL, OP_SLL, OP_ROR, OP_SRL
  - state codes ST_IDLE, ST_SHIFT, ST_DONE
  - WIDTH and CNT_W constants
- One combinational sub-module, shift_step1, computes the 1-bit step.
  - Inputs: d[15:0], op[1:0]. Output: q[15:0].
  - The controller instantiates it once.
  - Under SHIFT_BY4_EN it is instantiated four times in a chain for the 4-bit step; the 1-bit result is taken from the first instance.

## Test plan
- rol, in_data=16'h8001, cnt=1, out_ready=1: expect out_data=16'h0003, with out_valid in the cycle after E1.
- rol, 16'h1234, cnt=4: expect 16'h2341 after 4 step edges (1 step edge with SHIFT_BY4_EN). ror, 16'h1234, cnt=4: expect 16'h4123.
- srl, 16'h8000, cnt=15: expect 16'h0001. sll, 16'hFFFF, cnt=15: expect 16'h8000. Step-edge count is 15, or 6 with SHIFT_BY4_EN.
- sll, 16'hABCD, cnt=0: expect out_valid in the cycle after accept and out_data=16'hABCD. Throughout, in_valid held high with changing in_data must not disturb the op in flight.
- Backpressure: out_ready low for 5 cycles in DONE. out_valid and out_data must stay stable and in_ready must stay 0. When out_ready goes high, in_ready must be 1 in the next cycle, and a back-to-back request is accepted.
- Reset: assert rst_n low mid-SHIFT (rol 16'h00FF, cnt=8, after 3 steps). All outputs must take their reset values immediately. After release, a new request (ror 16'h0001, cnt=1) returns 16'h8000.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants, op codes and state codes for the shift sequencer.
// Optional SHIFT_BY4_EN selects a 4-bit stride in the controller.
package shift_ctrl_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle for the shift sequencer.
interface shift_seq_ctrl_if;
    import shift_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_step1.sv
// One-bit rotate/shift stage used by the shift sequencer.
module shift_step1
    import shift_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        unique case (op)
            OP_ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_SLL: q = {d[WIDTH-2:0], 1'b0};
            OP_ROR: q = {d[0], d[WIDTH-1:1]};
            OP_SRL: q = {1'b0, d[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle rotate/shift sequencer built on a single 1-bit stage.
// Define SHIFT_BY4_EN to step by 4 bits while at least 4 remain.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    shift_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] step1;

    shift_step1 u_s0 (.d(work_q), .op(op_q), .q(step1));

`ifdef SHIFT_BY4_EN
    logic [WIDTH-1:0] step2, step3, step4;

    shift_step1 u_s1 (.d(step1), .op(op_q), .q(step2));
    shift_step1 u_s2 (.d(step2), .op(op_q), .q(step3));
    shift_step1 u_s3 (.d(step3), .op(op_q), .q(step4));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        op_d   = op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.in_data;
                    rem_d  = bus.in_cnt;
                    op_d   = bus.in_op;
                end
            end
            ST_SHIFT: begin
                if (rem_q != '0) begin
`ifdef SHIFT_BY4_EN
                    if (rem_q >= CNT_W'(4)) begin
                        work_d = step4;
                        rem_d  = rem_q - CNT_W'(4);
                    end else begin
                        work_d = step1;
                        rem_d  = rem_q - CNT_W'(1);
                    end
`else
                    work_d = step1;
                    rem_d  = rem_q - CNT_W'(1);
`endif
                end
            end
            default: ;
        endcase
    end

    // Stray encoding 11 falls through to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid)
                    state_d = (bus.in_cnt != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (rem_d == '0)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        bus.out_data  = work_q;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl.
module tb_shift_seq_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_seq_ctrl_if bus ();

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_edges(input logic [3:0] c);
`ifdef SHIFT_BY4_EN
        return int'(c[3:2]) + int'(c[1:0]);
`else
        return int'(c);
`endif
    endfunction

    // Caller is #1 after an edge with the DUT in IDLE.
    task automatic run_op(input logic [1:0] op, input logic [15:0] data,
                          input logic [3:0] cnt, input logic [15:0] expd,
                          input int bp);
        int k;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_data   = data;
        bus.in_cnt    = cnt;
        bus.out_ready = (bp == 0);
        chk("rdy_pre", {15'd0, bus.in_ready}, 16'd1);
        @(posedge clk); #1;
        bus.in_data = ~data;
        bus.in_op   = op ^ 2'b01;
        bus.in_cnt  = ~cnt;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        bus.in_valid = 1'b0;
        chk("edges", 16'(k), 16'(exp_edges(cnt)));
        chk("data", bus.out_data, expd);
        chk("busy", {15'd0, bus.busy}, 16'd1);
        chk("rdy_done", {15'd0, bus.in_ready}, 16'd0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_vld", {15'd0, bus.out_valid}, 16'd1);
            chk("bp_data", bus.out_data, expd);
            chk("bp_rdy", {15'd0, bus.in_ready}, 16'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rdy_post", {15'd0, bus.in_ready}, 16'd1);
        chk("vld_post", {15'd0, bus.out_valid}, 16'd0);
        chk("busy_post", {15'd0, bus.busy}, 16'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cnt    = '0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", {15'd0, bus.in_ready}, 16'd1);
        chk("rst_vld", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_data", bus.out_data, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 16'h8001, 4'd1,  16'h0003, 0);
        run_op(2'b00, 16'h1234, 4'd4,  16'h2341, 0);
        run_op(2'b10, 16'h1234, 4'd4,  16'h4123, 0);
        run_op(2'b11, 16'h8000, 4'd15, 16'h0001, 0);
        run_op(2'b01, 16'hFFFF, 4'd15, 16'h8000, 0);
        run_op(2'b01, 16'hABCD, 4'd0,  16'hABCD, 0);
        run_op(2'b00, 16'hABCD, 4'd0,  16'hABCD, 0);
        run_op(2'b10, 16'h0001, 4'd15, 16'h0002, 0);
        run_op(2'b01, 16'h00F3, 4'd6,  16'h3CC0, 0);
        run_op(2'b11, 16'h00F0, 4'd4,  16'h000F, 5);
        run_op(2'b00, 16'h0F00, 4'd9,  16'h001E, 0);

        bus.in_valid = 1'b1;
        bus.in_op    = 2'b00;
        bus.in_data  = 16'h00FF;
        bus.in_cnt   = 4'd8;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rdy", {15'd0, bus.in_ready}, 16'd1);
        chk("mid_vld", {15'd0, bus.out_valid}, 16'd0);
        chk("mid_busy", {15'd0, bus.busy}, 16'd0);
        chk("mid_data", bus.out_data, 16'h0000);
        @(posedge clk); #1;
        chk("hold_vld", {15'd0, bus.out_valid}, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b10, 16'h0001, 4'd1, 16'h8000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
